hh_exp_arbiter: RTL and testbench

Round-robin scheduler that shares one Q10.12 CORDIC exponential engine among the HH neuron's rate-function requesters (alpha/beta terms for m, h, n). It accepts one pending argument per requester, sequences the engine through a start/done handshake, and routes each result back to its requester. A watchdog recovers from a hung engine. It sits between the gating-variable update logic and the single shared exp datapath.

---
 rtl/hh_exp_arbiter.sv | 161 ++++++++++++++++
 tb/tb_hh_exp_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hh_exp_arbiter.sv
// Round-robin arbiter sharing one CORDIC exp engine among the HH rate-function requesters.
// Sequences the engine through start/done and aborts a hung engine with a watchdog.
module hh_exp_arbiter #(
   parameter int NREQ    = 6,
   parameter int W       = 22,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_x,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   output logic              eng_start,
   output logic [W-1:0]      eng_x,
   output logic              eng_rst,
   input  logic [W-1:0]      eng_result,
   input  logic              eng_done,
   output logic              busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            abort_q, abort_d;
   logic [NREQ-1:0] rspValid_q, rspValid_d;
   logic [W-1:0]    rspData_q, rspData_d;
   logic            rspErr_q, rspErr_d;
   logic            engStart_q, engStart_d;
   logic [W-1:0]    engX_q, engX_d;
   logic            engRst_q, engRst_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [PW-1:0]   pick;
   logic [PW:0]     sum;
   logic [NREQ-1:0] gntMask;

   // Cyclic search starting just above the last grant; the first pending requester wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         if (!found && req_valid[sum[PW-1:0]]) begin
            found = 1'b1;
            pick  = sum[PW-1:0];
         end
      end
   end

   always_comb begin
      gntMask = '0;
      for (int j = 0; j < NREQ; j++) gntMask[j] = (gnt_q == PW'(j));
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      abort_d    = abort_q;
      engX_d     = engX_q;
      engStart_d = 1'b0;
      engRst_d   = 1'b0;
      rspValid_d = '0;
      rspData_d  = '0;
      rspErr_d   = 1'b0;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = pick;
               ptr_d = pick;
               for (int j = 0; j < NREQ; j++) begin
                  if (pick == PW'(j)) engX_d = req_x[j*W +: W];
               end
               engStart_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CW'(1);
            abort_d = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            // After a timeout, one extra cycle lets eng_rst land before the error response.
            if (abort_q) begin
               rspValid_d = gntMask;
               rspErr_d   = 1'b1;
               state_d    = RESP;
            end else if (eng_done) begin
               rspValid_d = gntMask;
               rspData_d  = eng_result;
               state_d    = RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               abort_d  = 1'b1;
               engRst_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            abort_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= PW'(NREQ-1);
         gnt_q      <= '0;
         cnt_q      <= '0;
         abort_q    <= 1'b0;
         rspValid_q <= '0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
         engStart_q <= 1'b0;
         engX_q     <= '0;
         engRst_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         cnt_q      <= cnt_d;
         abort_q    <= abort_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
         rspErr_q   <= rspErr_d;
         engStart_q <= engStart_d;
         engX_q     <= engX_d;
         engRst_q   <= engRst_d;
         busy_q     <= busy_d;
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_data  = rspData_q;
   assign rsp_err   = rspErr_q;
   assign eng_start = engStart_q;
   assign eng_x     = engX_q;
   assign eng_rst   = engRst_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_hh_exp_arbiter.sv
// Bench for hh_exp_arbiter: directed scenarios plus randomized traffic, checked against
// a round-robin reference model and a latency-programmable exp engine model.
module tb_hh_exp_arbiter;

   localparam int NREQ    = 6;
   localparam int W       = 22;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              rsp_err;
   logic              eng_start;
   logic [W-1:0]      eng_x;
   logic              eng_rst;
   logic [W-1:0]      eng_result = '0;
   logic              eng_done = 1'b0;
   logic              busy;

   hh_exp_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .eng_start  (eng_start),
      .eng_x      (eng_x),
      .eng_rst    (eng_rst),
      .eng_result (eng_result),
      .eng_done   (eng_done),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   int              engLat   = 5;
   bit              engHang  = 1'b0;
   bit              spurious = 1'b0;
   int              engCnt   = 0;
   logic [W-1:0]    engArg   = '0;
   int              cyc      = 0;
   int              passed   = 0;
   int              total    = 0;
   int              rstCycle = -1;
   bit              sawRst   = 1'b0;
   logic [NREQ-1:0] pend     = '0;
   logic [W-1:0]    arg [NREQ];
   int              refPtr   = NREQ-1;

   // Stand-in for the exp datapath: 1.0 maps to e, anything else to an arbitrary bijection.
   function automatic logic [W-1:0] expFn(input logic [W-1:0] x);
      if (x == 22'h001000) return 22'h002B7E;
      return (x ^ 22'h2A5A5) + 22'd13;
   endfunction

   // Engine model: acts 2 ns after each edge, answers engLat cycles after eng_start unless
   // hung, forgets its job on either reset, and scribbles on eng_result while not done.
   always begin
      @(posedge clk);
      #2;
      eng_done   = 1'b0;
      eng_result = W'($urandom);
      if (rst || eng_rst) begin
         engCnt = 0;
      end else if (eng_start) begin
         engArg = eng_x;
         engCnt = engHang ? 0 : engLat;
      end else if (engCnt > 0) begin
         engCnt--;
         if (engCnt == 0) begin
            eng_done   = 1'b1;
            eng_result = expFn(engArg);
         end
      end
      if (spurious) begin
         eng_done   = 1'b1;
         eng_result = 22'h3FFFFF;
      end
   end

   // Round-robin reference: first pending requester strictly after the last one served.
   function automatic int modelPick();
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (refPtr + k) % NREQ;
         if (pend[j]) return j;
      end
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (eng_rst) begin
         sawRst   = 1'b1;
         rstCycle = cyc;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] v);
      pend      = v;
      req_valid = v;
      for (int j = 0; j < NREQ; j++) req_x[j*W +: W] = arg[j];
   endtask

   task automatic waitStart(input string tag, output int winner, output int sCyc);
      bit seen;
      seen   = 1'b0;
      winner = modelPick();
      for (int k = 0; k < 6 && !seen; k++) begin
         step();
         if (eng_start) seen = 1'b1;
      end
      sCyc = cyc;
      checkOutput({tag, "_start_seen"}, 64'(seen), 64'd1);
      checkOutput({tag, "_eng_x"}, 64'(eng_x), 64'(arg[winner]));
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic waitResp(input string tag, input int winner, input bit expErr, output int rCyc);
      bit              seen;
      logic [NREQ-1:0] mask;
      logic [W-1:0]    data;
      seen         = 1'b0;
      mask         = '0;
      mask[winner] = 1'b1;
      data         = expErr ? '0 : expFn(arg[winner]);
      for (int k = 0; k < TIMEOUT + 20 && !seen; k++) begin
         step();
         if (rsp_valid != '0) seen = 1'b1;
      end
      rCyc = cyc;
      checkOutput({tag, "_rsp_seen"}, 64'(seen), 64'd1);
      checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(mask));
      checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(data));
      checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'(expErr));
      refPtr = winner;
   endtask

   // Safety net in case a wait somehow escapes its bound.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   // Directed scenarios followed by randomized traffic, in one linear sequence.
   initial begin
      int              c, s, r, w;
      logic [NREQ-1:0] tmp;
      rst = 1'b1;
      for (int j = 0; j < NREQ; j++) arg[j] = '0;
      applyStimulus('0);
      repeat (3) step();
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
      checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
      checkOutput("reset_eng_start", 64'(eng_start), 64'd0);
      checkOutput("reset_eng_x", 64'(eng_x), 64'd0);
      checkOutput("reset_eng_rst", 64'(eng_rst), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();

      $display("[TB] single request, L=5");
      arg[0] = 22'h001000;
      engLat = 5;
      applyStimulus(6'b000001);
      c = cyc;
      waitStart("single", w, s);
      checkOutput("single_start_lat", 64'(s - c), 64'd1);
      waitResp("single", w, 1'b0, r);
      checkOutput("single_rsp_lat", 64'(r - c), 64'd7);
      applyStimulus('0);

      $display("[TB] all requesters after reset");
      rst = 1'b1;
      step();
      rst    = 1'b0;
      refPtr = NREQ-1;
      for (int j = 0; j < NREQ; j++) arg[j] = W'(32'h100 * (j + 1) + 32'h11);
      engLat = 2;
      applyStimulus('1);
      for (int t = 0; t < NREQ + 1; t++) begin
         waitStart($sformatf("allreq%0d", t), w, s);
         waitResp($sformatf("allreq%0d", t), w, 1'b0, r);
         tmp    = '1;
         tmp[w] = 1'b0;
         applyStimulus(tmp);
      end
      applyStimulus('0);
      step();

      $display("[TB] hung engine");
      engHang  = 1'b1;
      sawRst   = 1'b0;
      rstCycle = -1;
      arg[3]   = 22'h3F0A1C;
      applyStimulus(6'b001000);
      waitStart("hang", w, s);
      waitResp("hang", w, 1'b1, r);
      checkOutput("hang_eng_rst_cycle", 64'(rstCycle - s), 64'(TIMEOUT));
      checkOutput("hang_rsp_cycle", 64'(r - s), 64'(TIMEOUT + 1));
      engHang = 1'b0;
      engLat  = 3;
      arg[1]  = W'($urandom);
      applyStimulus(6'b000010);
      waitStart("after_hang", w, s);
      waitResp("after_hang", w, 1'b0, r);
      applyStimulus('0);

      $display("[TB] done coincident with timeout");
      engLat = TIMEOUT - 1;
      sawRst = 1'b0;
      arg[2] = W'($urandom);
      applyStimulus(6'b000100);
      waitStart("coinc", w, s);
      waitResp("coinc", w, 1'b0, r);
      checkOutput("coinc_rsp_cycle", 64'(r - s), 64'(TIMEOUT));
      checkOutput("coinc_no_eng_rst", 64'(sawRst), 64'd0);
      applyStimulus('0);

      $display("[TB] reset during WAIT");
      engLat = 20;
      arg[2] = W'($urandom);
      applyStimulus(6'b000100);
      waitStart("rstwait", w, s);
      repeat (3) step();
      rst = 1'b1;
      step();
      checkOutput("rstwait_ctrl", 64'({rsp_valid, rsp_err, eng_start, eng_rst, busy}), 64'd0);
      checkOutput("rstwait_eng_x", 64'(eng_x), 64'd0);
      checkOutput("rstwait_rsp_data", 64'(rsp_data), 64'd0);
      step();
      checkOutput("rstwait_no_rsp", 64'(rsp_valid), 64'd0);
      rst    = 1'b0;
      refPtr = NREQ-1;
      engLat = 4;
      arg[0] = W'($urandom);
      arg[5] = W'($urandom);
      applyStimulus(6'b100101);
      for (int t = 0; t < 3; t++) begin
         waitStart($sformatf("postrst%0d", t), w, s);
         waitResp($sformatf("postrst%0d", t), w, 1'b0, r);
         tmp    = pend;
         tmp[w] = 1'b0;
         applyStimulus(tmp);
      end

      $display("[TB] requester withdraws before grant");
      engLat = 6;
      arg[1] = W'($urandom);
      applyStimulus(6'b000010);
      waitStart("drop", w, s);
      arg[3] = W'($urandom);
      arg[4] = W'($urandom);
      applyStimulus(6'b011010);
      step();
      applyStimulus(6'b010010);
      waitResp("drop", w, 1'b0, r);
      applyStimulus(6'b010000);
      waitStart("drop_req4", w, s);
      waitResp("drop_req4", w, 1'b0, r);
      applyStimulus('0);
      for (int k = 0; k < 4; k++) begin
         spurious = (k % 2 == 0);
         step();
         checkOutput($sformatf("spur%0d_rsp_valid", k), 64'(rsp_valid), 64'd0);
         checkOutput($sformatf("spur%0d_busy", k), 64'(busy), 64'd0);
         checkOutput($sformatf("spur%0d_eng_start", k), 64'(eng_start), 64'd0);
      end
      spurious = 1'b0;

      $display("[TB] randomized traffic");
      tmp = NREQ'($urandom);
      if (tmp == '0) tmp[0] = 1'b1;
      for (int j = 0; j < NREQ; j++) arg[j] = W'($urandom);
      applyStimulus(tmp);
      for (int t = 0; t < 30; t++) begin
         engLat = $urandom_range(1, 8);
         waitStart($sformatf("rand%0d", t), w, s);
         waitResp($sformatf("rand%0d", t), w, 1'b0, r);
         tmp    = pend;
         tmp[w] = 1'b0;
         for (int j = 0; j < NREQ; j++) begin
            if (j != w && !tmp[j] && $urandom_range(0, 1) == 1) begin
               arg[j] = W'($urandom);
               tmp[j] = 1'b1;
            end
         end
         if (tmp == '0) begin
            int j2;
            j2       = (w + 1 + $urandom_range(0, NREQ - 2)) % NREQ;
            arg[j2]  = W'($urandom);
            tmp[j2]  = 1'b1;
         end
         applyStimulus(tmp);
      end
      applyStimulus('0);
      repeat (2) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
